// File: rtl/cgra_exec_pkg.sv
// Shared state encoding and sizing helpers for the CGRA execution controller.
package cgra_exec_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_RUN     = 3'd1;
    localparam logic [ST_W-1:0] ST_DRAIN   = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT_WR = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE    = 3'd4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Drain counter only ever holds 0 .. n-1, but never narrower than one bit.
    function automatic int unsigned drain_cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/cgra_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module cgra_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !(&r_count)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/cgra_exec_ctrl.sv
// Multi-channel CGRA execution controller: arms on start, gates the CGRA enable
// on stream readiness, drains the pipeline, then waits for every output to finish.
module cgra_exec_ctrl
    import cgra_exec_pkg::*;
#(
    parameter int unsigned NUM_IN       = 1,
    parameter int unsigned NUM_OUT      = 1,
    parameter int unsigned DRAIN_CYCLES = 16,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_IN-1:0]    read_fifo_mask,
    input  logic [NUM_OUT-1:0]   write_fifo_mask,
    input  logic [NUM_IN-1:0]    available_pop,
    input  logic [NUM_OUT-1:0]   available_push,
    input  logic [NUM_IN-1:0]    read_fifo_done,
    input  logic [NUM_OUT-1:0]   write_fifo_done,
    output logic                 en,
    output logic [NUM_IN-1:0]    en_fecth_data,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] exec_cycles,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int unsigned DCW = drain_cnt_width(DRAIN_CYCLES);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_next_state;
    logic [NUM_IN-1:0]  r_rmask;
    logic [NUM_IN-1:0]  r_rd_done;
    logic [NUM_OUT-1:0] r_wmask;
    logic [NUM_OUT-1:0] r_wr_done;
    logic [DCW-1:0]     r_drain_cnt;
    logic               r_done;

    logic               w_accept;
    logic               w_active;
    logic               w_in_ok_all;
    logic               w_out_ok_all;
    logic               w_rd_exhausted;
    logic               w_wr_all_done;
    logic               w_drain_last;
    logic               w_en;
    logic [NUM_IN-1:0]  w_fetch;

    assign w_in_ok_all    = &(~r_rmask | available_pop | r_rd_done);
    assign w_out_ok_all   = &(~r_wmask | available_push);
    assign w_rd_exhausted = &(~r_rmask | (r_rd_done & ~available_pop));
    assign w_wr_all_done  = &(~r_wmask | r_wr_done);
    assign w_accept       = start & ~abort & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    assign w_active       = (r_state == ST_RUN) | (r_state == ST_DRAIN);

    // Last drain cycle is the one that issues the DRAIN_CYCLES-th enable.
    assign w_drain_last = (DRAIN_CYCLES == 0) ||
                          (w_out_ok_all &&
                           (({1'b0, r_drain_cnt} + (DCW+1)'(1)) == (DCW+1)'(DRAIN_CYCLES)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_en         = 1'b0;
        w_fetch      = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                w_en    = w_in_ok_all & w_out_ok_all;
                w_fetch = r_rmask & ~r_rd_done;
                if (w_rd_exhausted) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_en = w_out_ok_all;
                if (w_drain_last) w_next_state = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                if (w_wr_all_done) w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (abort) begin
            w_next_state = ST_IDLE;
            w_en         = 1'b0;
            w_fetch      = '0;
        end
    end

    // Channel masks, sticky done flags, drain counter and the held done flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rmask     <= '0;
            r_wmask     <= '0;
            r_rd_done   <= '0;
            r_wr_done   <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (w_next_state == ST_DONE);
            if (w_accept) begin
                r_rmask     <= read_fifo_mask;
                r_wmask     <= write_fifo_mask;
                r_rd_done   <= '0;
                r_wr_done   <= '0;
                r_drain_cnt <= '0;
            end else begin
                if (r_state != ST_IDLE) begin
                    r_rd_done <= r_rd_done | read_fifo_done;
                    r_wr_done <= r_wr_done | write_fifo_done;
                end
                if ((r_state == ST_DRAIN) && w_en) begin
                    r_drain_cnt <= r_drain_cnt + DCW'(1);
                end
            end
        end
    end

    cgra_sat_counter #(.WIDTH(CNT_WIDTH)) u_exec_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .inc   (w_active),
        .count (exec_cycles)
    );

    cgra_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept),
        .inc   (w_active & ~w_en),
        .count (stall_cycles)
    );

    assign en            = w_en;
    assign en_fecth_data = w_fetch;
    assign done          = r_done;

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Bench for cgra_exec_ctrl: directed vector table, corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_cgra_exec_ctrl;

    localparam int NI   = 2;
    localparam int NO   = 1;
    localparam int DC   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start, abort;
    logic [NI-1:0] rmask, pop, rdone;
    logic [NO-1:0] wmask, push, wdone;
    logic          en, done;
    logic [NI-1:0] fetch;
    logic [CW-1:0] exec_c, stall_c;

    logic       b_start;
    logic [0:0] b_zero, b_fetch;
    logic       b_en, b_done;
    logic [7:0] b_exec, b_stall;

    cgra_exec_ctrl #(.NUM_IN(NI), .NUM_OUT(NO), .DRAIN_CYCLES(DC), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .read_fifo_mask(rmask), .write_fifo_mask(wmask),
        .available_pop(pop), .available_push(push),
        .read_fifo_done(rdone), .write_fifo_done(wdone),
        .en(en), .en_fecth_data(fetch), .done(done),
        .exec_cycles(exec_c), .stall_cycles(stall_c)
    );

    cgra_exec_ctrl #(.NUM_IN(1), .NUM_OUT(1), .DRAIN_CYCLES(0), .CNT_WIDTH(8)) u_dut_nodrain (
        .clk(clk), .rst(rst), .start(b_start), .abort(1'b0),
        .read_fifo_mask(b_zero), .write_fifo_mask(b_zero),
        .available_pop(b_zero), .available_push(b_zero),
        .read_fifo_done(b_zero), .write_fifo_done(b_zero),
        .en(b_en), .en_fecth_data(b_fetch), .done(b_done),
        .exec_cycles(b_exec), .stall_cycles(b_stall)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed vectors: one row per clock; ex/sl of -1 means counter not checked.
    typedef struct {
        bit st; bit ab; bit [1:0] rm; bit wm; bit [1:0] pp; bit ps; bit [1:0] rd; bit wd;
        bit e; bit [1:0] f; bit d; int ex; int sl;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit st, ab, input bit [1:0] rm, input bit wm,
                                input bit [1:0] pp, input bit ps, input bit [1:0] rd,
                                input bit wd, input bit e, input bit [1:0] f, input bit d,
                                input int ex, input int sl);
        vec_t v;
        v.st = st; v.ab = ab; v.rm = rm; v.wm = wm; v.pp = pp; v.ps = ps; v.rd = rd;
        v.wd = wd; v.e = e; v.f = f; v.d = d; v.ex = ex; v.sl = sl;
        tbl.push_back(v);
    endfunction

    // Reference model, tracked per transaction phase.
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_WAIT, M_DONE} mst_t;
    mst_t          m_st;
    bit [NI-1:0]   m_rm, m_rd;
    bit [NO-1:0]   m_wm, m_wr;
    int            m_dcnt, m_exec, m_stall;
    bit            m_done;

    function automatic void model_reset();
        m_st = M_IDLE; m_rm = '0; m_rd = '0; m_wm = '0; m_wr = '0;
        m_dcnt = 0; m_exec = 0; m_stall = 0; m_done = 1'b0;
    endfunction

    function automatic bit model_en();
        bit ok;
        if (abort || !(m_st == M_RUN || m_st == M_DRAIN)) return 1'b0;
        ok = 1'b1;
        for (int j = 0; j < NO; j++) if (m_wm[j] && !push[j]) ok = 1'b0;
        if (m_st == M_RUN)
            for (int i = 0; i < NI; i++) if (m_rm[i] && !pop[i] && !m_rd[i]) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit [NI-1:0] model_fetch();
        bit [NI-1:0] f;
        f = '0;
        if (!abort && m_st == M_RUN)
            for (int i = 0; i < NI; i++) f[i] = m_rm[i] && !m_rd[i];
        return f;
    endfunction

    function automatic void model_step();
        mst_t nst;
        bit   e, acc, all;
        e   = model_en();
        acc = start && !abort && (m_st == M_IDLE || m_st == M_DONE);
        if (m_st == M_RUN || m_st == M_DRAIN) begin
            if (m_exec < CMAX) m_exec++;
            if (!e && m_stall < CMAX) m_stall++;
        end
        nst = m_st;
        case (m_st)
            M_IDLE, M_DONE: if (start) nst = M_RUN;
            M_RUN: begin
                all = 1'b1;
                for (int i = 0; i < NI; i++) if (m_rm[i] && !(m_rd[i] && !pop[i])) all = 1'b0;
                if (all) nst = M_DRAIN;
            end
            M_DRAIN: begin
                if (e) m_dcnt++;
                if (DC == 0 || m_dcnt == DC) nst = M_WAIT;
            end
            M_WAIT: begin
                all = 1'b1;
                for (int j = 0; j < NO; j++) if (m_wm[j] && !m_wr[j]) all = 1'b0;
                if (all) nst = M_DONE;
            end
            default: ;
        endcase
        if (abort) nst = M_IDLE;
        if (m_st != M_IDLE) begin
            m_rd = m_rd | rdone;
            m_wr = m_wr | wdone;
        end
        if (acc) begin
            m_rm = rmask; m_wm = wmask; m_rd = '0; m_wr = '0;
            m_dcnt = 0; m_exec = 0; m_stall = 0;
        end
        m_done = (nst == M_DONE);
        m_st   = nst;
    endfunction

    initial begin
        int got;
        start = 0; abort = 0; rmask = '0; wmask = '0; pop = '0; push = '0;
        rdone = '0; wdone = '0; b_start = 0; b_zero = '0;

        //      st ab rm    wm pp    ps rd    wd | e f     d  ex  sl
        add(1, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  0, 2'b00, 0, 0,  0);
        add(0, 0, 2'b11, 1, 2'b01, 1, 2'b00, 0,  0, 2'b11, 0, 0,  0);
        add(0, 0, 2'b11, 1, 2'b11, 1, 2'b00, 0,  1, 2'b11, 0, 1,  1);
        add(0, 0, 2'b11, 1, 2'b11, 0, 2'b00, 0,  0, 2'b11, 0, 2,  1);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b11, 0,  0, 2'b11, 0, 3,  2);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  1, 2'b00, 0, 4,  3);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  1, 2'b00, 0, 5,  3);
        add(0, 0, 2'b11, 1, 2'b00, 0, 2'b00, 0,  0, 2'b00, 0, 6,  3);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  1, 2'b00, 0, 7,  4);
        add(0, 0, 2'b11, 1, 2'b00, 0, 2'b00, 0,  0, 2'b00, 0, 8,  4);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  1, 2'b00, 0, 9,  5);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  1, 2'b00, 0, 10, 5);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 1,  0, 2'b00, 0, 11, 5);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  0, 2'b00, 0, 11, 5);
        add(0, 0, 2'b11, 1, 2'b00, 1, 2'b00, 0,  0, 2'b00, 1, 11, 5);
        add(1, 0, 2'b01, 1, 2'b00, 1, 2'b00, 0,  0, 2'b00, 1, 11, 5);
        add(0, 0, 2'b01, 1, 2'b01, 1, 2'b00, 0,  1, 2'b01, 0, 0,  0);
        add(0, 0, 2'b01, 1, 2'b00, 1, 2'b00, 0,  0, 2'b01, 0, 1,  0);
        add(0, 0, 2'b01, 1, 2'b01, 1, 2'b01, 0,  1, 2'b01, 0, 2,  1);
        add(0, 0, 2'b01, 1, 2'b01, 1, 2'b00, 0,  1, 2'b00, 0, 3,  1);
        add(0, 0, 2'b01, 1, 2'b00, 1, 2'b00, 0,  1, 2'b00, 0, 4,  1);
        add(0, 1, 2'b01, 1, 2'b00, 1, 2'b00, 0,  0, 2'b00, 0, 5,  1);
        add(0, 0, 2'b01, 1, 2'b00, 1, 2'b00, 0,  0, 2'b00, 0, -1, -1);
        add(1, 1, 2'b11, 1, 2'b11, 1, 2'b00, 0,  0, 2'b00, 0, -1, -1);
        add(1, 0, 2'b11, 1, 2'b11, 1, 2'b00, 0,  0, 2'b00, 0, -1, -1);
        add(0, 0, 2'b11, 1, 2'b11, 1, 2'b00, 0,  1, 2'b11, 0, 0,  0);
        add(1, 0, 2'b11, 1, 2'b11, 1, 2'b00, 0,  1, 2'b11, 0, 1,  0);
        add(0, 0, 2'b11, 1, 2'b11, 1, 2'b00, 0,  1, 2'b11, 0, 2,  0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_en", en, 0);
        chk("reset_exec", exec_c, 0);
        rst = 1'b0;

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            start = tbl[k].st; abort = tbl[k].ab; rmask = tbl[k].rm; wmask = tbl[k].wm;
            pop = tbl[k].pp; push = tbl[k].ps; rdone = tbl[k].rd; wdone = tbl[k].wd;
            @(negedge clk);
            chk($sformatf("vec%0d_en", k), en, tbl[k].e);
            chk($sformatf("vec%0d_fetch", k), fetch, tbl[k].f);
            chk($sformatf("vec%0d_done", k), done, tbl[k].d);
            if (tbl[k].ex >= 0) chk($sformatf("vec%0d_exec", k), exec_c, tbl[k].ex);
            if (tbl[k].sl >= 0) chk($sformatf("vec%0d_stall", k), stall_c, tbl[k].sl);
        end

        // Long RUN: exec counter must stick at all-ones.
        @(posedge clk); #1;
        start = 0; pop = 2'b11; push = 1'b1; rdone = '0; wdone = '0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_exec", exec_c, CMAX);
        chk("sat_stall", stall_c, 0);
        chk("sat_en", en, 1);

        // Reset mid-RUN clears everything without waiting for a clock.
        #2 rst = 1'b1;
        #1;
        chk("arst_en", en, 0);
        chk("arst_fetch", fetch, 0);
        chk("arst_done", done, 0);
        chk("arst_exec", exec_c, 0);
        chk("arst_stall", stall_c, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            start = ($urandom % 4) == 0;
            abort = ($urandom % 50) == 0;
            rmask = NI'($urandom);
            wmask = NO'($urandom);
            pop   = NI'($urandom);
            push  = NO'(($urandom % 4) != 0);
            for (int i = 0; i < NI; i++) rdone[i] = ($urandom % 12) == 0;
            for (int j = 0; j < NO; j++) wdone[j] = ($urandom % 10) == 0;
            @(negedge clk);
            chk("rnd_en", en, model_en());
            chk("rnd_fetch", fetch, model_fetch());
            chk("rnd_done", done, m_done);
            chk("rnd_exec", exec_c, m_exec);
            chk("rnd_stall", stall_c, m_stall);
            model_step();
        end

        // Zero masks with no drain phase: done within four cycles of start.
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        got = 0;
        for (int c = 1; c <= 4 && got == 0; c++) begin
            @(posedge clk); #1;
            if (b_done) got = c;
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL nodrain_done: done not seen within 4 cycles, required by cycle 4");
        end
        chk("nodrain_exec", b_exec, 2);
        chk("nodrain_stall", b_stall, 0);
        chk("nodrain_en", b_en, 0);
        chk("nodrain_fetch", b_fetch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
